// File: rtl/log_norm_pkg.sv
// Shared definitions for the log-compression path (package log_pkg).
// Holds the controller state encoding, the default magnitude width and the
// exponent-width helper that the downstream log stage also uses.
package log_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      SEND = 2'd2
   } state_t;

   // Exponent width, which is also the number of binary-search steps.
   function automatic int shift_width(input int data_width);
      return $clog2(data_width);
   endfunction

endpackage

// File: rtl/log_norm_if.sv
// Sample/result handshake bundle for log_norm.
// Optional macro LOG_NORM_ZERO_FLAG_EN adds the zero_out result flag.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The sender holds valid and its payload steady until that edge;
// the receiver may change ready freely. Payload is only meaningful while
// valid is high.
interface log_norm_if #(
   parameter int DATA_WIDTH  = log_pkg::DEFAULT_DATA_WIDTH,
   parameter int SHIFT_WIDTH = log_pkg::shift_width(DATA_WIDTH)
);
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_WIDTH-1:0]  data_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_WIDTH-1:0]  norm_out;
   logic [SHIFT_WIDTH-1:0] shift_amt;
`ifdef LOG_NORM_ZERO_FLAG_EN
   logic                   zero_out;
`endif

   // Upstream producer / downstream consumer side.
   modport master (
      output in_valid,
      output data_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  norm_out,
`ifdef LOG_NORM_ZERO_FLAG_EN
      input  zero_out,
`endif
      input  shift_amt
   );

   // The normalizer itself.
   modport slave (
      input  in_valid,
      input  data_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output norm_out,
`ifdef LOG_NORM_ZERO_FLAG_EN
      output zero_out,
`endif
      output shift_amt
   );
endinterface

// File: rtl/log_norm.sv
// log_norm: finds the leading one of an unsigned magnitude with an iterative
// binary search and returns the left-normalized mantissa plus floor(log2).
// One sample in flight; SHIFT_WIDTH search cycles per sample.
// Optional macro LOG_NORM_ZERO_FLAG_EN adds a registered zero_out flag.
module log_norm
   import log_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SHIFT_WIDTH = shift_width(DATA_WIDTH)
) (
   input  logic       clk,
   input  logic       reset,
   log_norm_if.slave  bus,
   output state_t     state
);

   state_t                 state_q;
   logic                   in_ready_q;
   logic                   out_valid_q;
   logic [DATA_WIDTH-1:0]  norm_q;
   logic [SHIFT_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0]  work;
   logic [SHIFT_WIDTH-1:0] lzc;
   logic [SHIFT_WIDTH-1:0] step;
   logic                   zero;
`ifdef LOG_NORM_ZERO_FLAG_EN
   logic                   zero_out_q;
`endif

   logic [SHIFT_WIDTH-1:0] n_val;
   logic [DATA_WIDTH-1:0]  top_mask;
   logic                   top_zero;
   logic [DATA_WIDTH-1:0]  work_next;
   logic [SHIFT_WIDTH-1:0] lzc_next;

   // One search step: if the top 2^step bits are clear, shift them out.
   // n_val peaks at DATA_WIDTH/2, which still fits in SHIFT_WIDTH bits.
   always_comb begin
      n_val     = SHIFT_WIDTH'(1) << step;
      top_mask  = ~({DATA_WIDTH{1'b1}} >> n_val);
      top_zero  = ((work & top_mask) == '0);
      work_next = top_zero ? (work << n_val) : work;
      lzc_next  = top_zero ? (lzc + n_val) : lzc;
   end

   // Controller and datapath registers; every output is registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         norm_q      <= '0;
         shift_q     <= '0;
         work        <= '0;
         lzc         <= '0;
         step        <= '0;
         zero        <= 1'b0;
`ifdef LOG_NORM_ZERO_FLAG_EN
         zero_out_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  work       <= bus.data_in;
                  lzc        <= '0;
                  step       <= SHIFT_WIDTH'(SHIFT_WIDTH - 1);
                  zero       <= (bus.data_in == '0);
                  state_q    <= SCAN;
                  in_ready_q <= 1'b0;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            SCAN: begin
               work       <= work_next;
               lzc        <= lzc_next;
               step       <= step - 1'b1;
               in_ready_q <= 1'b0;
               if (step == '0) begin
                  // A zero input leaves work_next at 0 anyway; only the
                  // exponent needs forcing.
                  state_q     <= SEND;
                  out_valid_q <= 1'b1;
                  norm_q      <= work_next;
                  shift_q     <= zero ? '0 : (SHIFT_WIDTH'(DATA_WIDTH - 1) - lzc_next);
`ifdef LOG_NORM_ZERO_FLAG_EN
                  zero_out_q  <= zero;
`endif
               end
            end
            SEND: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.norm_out  = norm_q;
   assign bus.shift_amt = shift_q;
`ifdef LOG_NORM_ZERO_FLAG_EN
   assign bus.zero_out  = zero_out_q;
`endif
   assign state         = state_q;

endmodule

// File: tb/tb_log_norm.sv
// Directed testbench for log_norm (16-bit build).
// Optional macro LOG_NORM_ZERO_FLAG_EN also checks zero_out.
module tb_log_norm;
   import log_pkg::*;

   localparam int DW = 16;
   localparam int SW = 4;

   logic   clk;
   logic   reset;
   state_t dbg_state;
   int     n_cmp;
   int     n_err;
   int     cyc;

   log_norm_if #(.DATA_WIDTH(DW)) bus ();

   log_norm #(.DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .state (dbg_state)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Waits (bounded) until in_ready is high at a sample point.
   task automatic wait_ready(output bit ok);
      int n;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      ok = bus.in_ready;
   endtask

   // Presents one sample, returns edges from accept edge to out_valid.
   task automatic drive_sample(input logic [DW-1:0] d, output int lat, output bit ok);
      bit rdy;
      wait_ready(rdy);
      bus.in_valid = 1'b1;
      bus.data_in  = d;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.data_in  = 16'hDEAD;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      ok = rdy && bus.out_valid;
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.in_valid = 1'b1;
      bus.data_in = 16'h0001;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      n_cmp++; if (bus.norm_out !== 16'h0000) begin n_err++; $display("FAIL reset_norm got=%h exp=0000", bus.norm_out); end
      n_cmp++; if (bus.shift_amt !== 4'd0) begin n_err++; $display("FAIL reset_shift got=%0d exp=0", bus.shift_amt); end
`ifdef LOG_NORM_ZERO_FLAG_EN
      n_cmp++; if (bus.zero_out !== 1'b0) begin n_err++; $display("FAIL reset_zero_out got=%b exp=0", bus.zero_out); end
`endif
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL release_out_valid got=%b exp=0", bus.out_valid); end
   endtask

   // Smallest nonzero input; also checks latency and in_ready around SEND.
   task automatic test_min_value();
      int lat; bit ok;
      drive_sample(16'h0001, lat, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL min_timeout got=no_out_valid exp=out_valid"); end
      // out_valid rises on the 4th edge after the accept edge: 5 edges counting the accept edge.
      n_cmp++; if (lat !== SW) begin n_err++; $display("FAIL min_latency got=%0d exp=%0d", lat, SW); end
      n_cmp++; if (bus.norm_out !== 16'h8000) begin n_err++; $display("FAIL min_norm got=%h exp=8000", bus.norm_out); end
      n_cmp++; if (bus.shift_amt !== 4'd0) begin n_err++; $display("FAIL min_shift got=%0d exp=0", bus.shift_amt); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL min_in_ready_send got=%b exp=0", bus.in_ready); end
      handshake();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL min_out_valid_after got=%b exp=0", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL min_in_ready_after got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_patterns();
      logic [DW-1:0] vin  [3];
      logic [DW-1:0] vnorm[3];
      logic [SW-1:0] vsh  [3];
      int lat; bit ok;
      vin[0] = 16'h8000; vnorm[0] = 16'h8000; vsh[0] = 4'd15;
      vin[1] = 16'h00F3; vnorm[1] = 16'hF300; vsh[1] = 4'd7;
      vin[2] = 16'h0A00; vnorm[2] = 16'hA000; vsh[2] = 4'd11;
      for (int i = 0; i < 3; i++) begin
         drive_sample(vin[i], lat, ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL pat%0d_timeout got=no_out_valid exp=out_valid", i); end
         n_cmp++; if (bus.norm_out !== vnorm[i]) begin n_err++; $display("FAIL pat%0d_norm got=%h exp=%h", i, bus.norm_out, vnorm[i]); end
         n_cmp++; if (bus.shift_amt !== vsh[i]) begin n_err++; $display("FAIL pat%0d_shift got=%0d exp=%0d", i, bus.shift_amt, vsh[i]); end
`ifdef LOG_NORM_ZERO_FLAG_EN
         n_cmp++; if (bus.zero_out !== 1'b0) begin n_err++; $display("FAIL pat%0d_zero_out got=%b exp=0", i, bus.zero_out); end
`endif
         handshake();
      end
   endtask

   task automatic test_zero();
      int lat; bit ok;
      drive_sample(16'h0000, lat, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL zero_timeout got=no_out_valid exp=out_valid"); end
      n_cmp++; if (lat !== SW) begin n_err++; $display("FAIL zero_latency got=%0d exp=%0d", lat, SW); end
      n_cmp++; if (bus.norm_out !== 16'h0000) begin n_err++; $display("FAIL zero_norm got=%h exp=0000", bus.norm_out); end
      n_cmp++; if (bus.shift_amt !== 4'd0) begin n_err++; $display("FAIL zero_shift got=%0d exp=0", bus.shift_amt); end
`ifdef LOG_NORM_ZERO_FLAG_EN
      n_cmp++; if (bus.zero_out !== 1'b1) begin n_err++; $display("FAIL zero_flag got=%b exp=1", bus.zero_out); end
`endif
      handshake();
   endtask

   task automatic test_backpressure();
      int lat; bit ok;
      drive_sample(16'h1234, lat, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout got=no_out_valid exp=out_valid"); end
      bus.in_valid = 1'b1;
      bus.data_in  = 16'h0001;
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if (bus.norm_out !== 16'h91A0) begin n_err++; $display("FAIL bp_norm[%0d] got=%h exp=91a0", i, bus.norm_out); end
         n_cmp++; if (bus.shift_amt !== 4'd12) begin n_err++; $display("FAIL bp_shift[%0d] got=%0d exp=12", i, bus.shift_amt); end
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, bus.out_valid); end
         n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      handshake();
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_after got=%b exp=1", bus.in_ready); end
      n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL bp_state_after got=%0d exp=0", dbg_state); end
   endtask

   task automatic test_reset_abort();
      bit rdy; int lat; bit ok;
      wait_ready(rdy);
      bus.in_valid = 1'b1;
      bus.data_in  = 16'h0F00;
      @(posedge clk); #1;          // first SCAN cycle
      bus.in_valid = 1'b0;
      @(posedge clk); #1;          // second SCAN cycle
      n_cmp++; if (dbg_state !== SCAN) begin n_err++; $display("FAIL abort_pre_state got=%0d exp=1", dbg_state); end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid got=%b exp=0", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready got=%b exp=0", bus.in_ready); end
      n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL abort_release_in_ready got=%b exp=1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL abort_release_out_valid got=%b exp=0", bus.out_valid); end
      drive_sample(16'h0003, lat, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL abort_next_timeout got=no_out_valid exp=out_valid"); end
      n_cmp++; if (bus.norm_out !== 16'hC000) begin n_err++; $display("FAIL abort_next_norm got=%h exp=c000", bus.norm_out); end
      n_cmp++; if (bus.shift_amt !== 4'd1) begin n_err++; $display("FAIL abort_next_shift got=%0d exp=1", bus.shift_amt); end
      handshake();
   endtask

   // out_ready tied high: samples must follow every SHIFT_WIDTH+2 cycles.
   task automatic test_back_to_back();
      logic [DW-1:0] vin  [2];
      logic [DW-1:0] vnorm[2];
      logic [SW-1:0] vsh  [2];
      int acc[2];
      bit rdy;
      int n;
      vin[0] = 16'h0400; vnorm[0] = 16'h8000; vsh[0] = 4'd10;
      vin[1] = 16'h7FFF; vnorm[1] = 16'hFFFE; vsh[1] = 4'd14;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.data_in  = vin[i];
         wait_ready(rdy);
         @(posedge clk); #1;
         acc[i] = cyc;
         bus.in_valid = 1'b0;
         n = 0;
         while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         n_cmp++; if (!(rdy && bus.out_valid)) begin n_err++; $display("FAIL b2b%0d_timeout got=no_out_valid exp=out_valid", i); end
         n_cmp++; if (bus.norm_out !== vnorm[i]) begin n_err++; $display("FAIL b2b%0d_norm got=%h exp=%h", i, bus.norm_out, vnorm[i]); end
         n_cmp++; if (bus.shift_amt !== vsh[i]) begin n_err++; $display("FAIL b2b%0d_shift got=%0d exp=%0d", i, bus.shift_amt, vsh[i]); end
      end
      n_cmp++; if (acc[1] - acc[0] !== SW + 2) begin n_err++; $display("FAIL b2b_period got=%0d exp=%0d", acc[1] - acc[0], SW + 2); end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      bus.in_valid  = 1'b0;
      bus.data_in   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_min_value();
      test_patterns();
      test_zero();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
